// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one divider between N_REQ requesters.
// Operands and results pass through untouched; all outputs come straight from registers.
module div_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        i_rst_n,
    input  logic [N_REQ*DATA_WIDTH-1:0] i_req_a,
    input  logic [N_REQ*DATA_WIDTH-1:0] i_req_b,
    input  logic [N_REQ-1:0]            i_req_stb,
    output logic [N_REQ-1:0]            o_req_ack,
    output logic [DATA_WIDTH-1:0]       o_res_z,
    output logic [N_REQ-1:0]            o_res_stb,
    input  logic [N_REQ-1:0]            i_res_ack,
    output logic [DATA_WIDTH-1:0]       o_div_a,
    output logic [DATA_WIDTH-1:0]       o_div_b,
    output logic                        o_div_stb,
    input  logic                        i_div_ack,
    input  logic [DATA_WIDTH-1:0]       i_div_z,
    input  logic                        i_div_z_stb,
    output logic                        o_div_z_ack,
    output logic                        o_busy,
    output logic [2:0]                  o_grant_id,
    output logic [15:0]                 o_ops_done
);

    localparam int unsigned IdxW = $clog2(N_REQ);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitRes, StDeliver} state_e;

    state_e                state_q, state_d;
    logic [N_REQ-1:0]      req_ack_q, req_ack_d;
    logic [N_REQ-1:0]      res_stb_q, res_stb_d;
    logic [DATA_WIDTH-1:0] res_z_q, res_z_d;
    logic [DATA_WIDTH-1:0] div_a_q, div_a_d;
    logic [DATA_WIDTH-1:0] div_b_q, div_b_d;
    logic                  div_stb_q, div_stb_d;
    logic                  div_z_ack_q, div_z_ack_d;
    logic                  busy_q, busy_d;
    logic [IdxW-1:0]       grant_q, grant_d;
    logic [IdxW-1:0]       last_q, last_d;
    logic [15:0]           ops_q, ops_d;

    logic                  win_found;
    logic [IdxW-1:0]       win_idx;
    logic [DATA_WIDTH-1:0] win_a, win_b;
    logic [IdxW-1:0]       cand_idx;
    int unsigned           cand;
    logic                  issue_done;
    logic                  res_hit;

    assign issue_done = div_stb_q & i_div_ack;
    assign res_hit    = i_res_ack[grant_q];

    // Search starts one past the last completed grantee so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_a     = '0;
        win_b     = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = 32'(last_q) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = IdxW'(cand);
            if (!win_found && i_req_stb[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
                win_a     = i_req_a[cand*DATA_WIDTH +: DATA_WIDTH];
                win_b     = i_req_b[cand*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            req_ack_q   <= '0;
            res_stb_q   <= '0;
            res_z_q     <= '0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            div_stb_q   <= 1'b0;
            div_z_ack_q <= 1'b0;
            busy_q      <= 1'b0;
            grant_q     <= '0;
            last_q      <= IdxW'(N_REQ - 1);
            ops_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_ack_q   <= req_ack_d;
            res_stb_q   <= res_stb_d;
            res_z_q     <= res_z_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            div_stb_q   <= div_stb_d;
            div_z_ack_q <= div_z_ack_d;
            busy_q      <= busy_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            ops_q       <= ops_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (win_found)   state_d = StIssue;
            StIssue:   if (issue_done)  state_d = StWaitRes;
            StWaitRes: if (i_div_z_stb) state_d = StDeliver;
            StDeliver: if (res_hit)     state_d = StIdle;
            default:                    state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ack_d   = '0;
        div_z_ack_d = 1'b0;
        res_stb_d   = res_stb_q;
        res_z_d     = res_z_q;
        div_a_d     = div_a_q;
        div_b_d     = div_b_q;
        div_stb_d   = div_stb_q;
        grant_d     = grant_q;
        last_d      = last_q;
        ops_d       = ops_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    req_ack_d = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
                    div_a_d   = win_a;
                    div_b_d   = win_b;
                    grant_d   = win_idx;
                    div_stb_d = 1'b1;
                end
            end
            StIssue: begin
                if (issue_done) begin
                    div_stb_d = 1'b0;
                end
            end
            StWaitRes: begin
                if (i_div_z_stb) begin
                    res_z_d     = i_div_z;
                    div_z_ack_d = 1'b1;
                    res_stb_d   = {{(N_REQ-1){1'b0}}, 1'b1} << grant_q;
                end
            end
            StDeliver: begin
                if (res_hit) begin
                    res_stb_d = '0;
                    last_d    = grant_q;
                    ops_d     = ops_q + 16'd1;
                end
            end
            default: ;
        endcase
        busy_d = (state_d != StIdle);
    end

    assign o_req_ack   = req_ack_q;
    assign o_res_stb   = res_stb_q;
    assign o_res_z     = res_z_q;
    assign o_div_a     = div_a_q;
    assign o_div_b     = div_b_q;
    assign o_div_stb   = div_stb_q;
    assign o_div_z_ack = div_z_ack_q;
    assign o_busy      = busy_q;
    assign o_grant_id  = 3'(grant_q);
    assign o_ops_done  = ops_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: directed vector table, hand sequences, and randomized traffic
// checked against a round-robin/scoreboard model with a behavioural divider.
`timescale 1ns/1ps
module tb_div_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk;
    logic            i_rst_n;
    logic [N*DW-1:0] i_req_a;
    logic [N*DW-1:0] i_req_b;
    logic [N-1:0]    i_req_stb;
    logic [N-1:0]    o_req_ack;
    logic [DW-1:0]   o_res_z;
    logic [N-1:0]    o_res_stb;
    logic [N-1:0]    i_res_ack;
    logic [DW-1:0]   o_div_a;
    logic [DW-1:0]   o_div_b;
    logic            o_div_stb;
    logic            i_div_ack;
    logic [DW-1:0]   i_div_z;
    logic            i_div_z_stb;
    logic            o_div_z_ack;
    logic            o_busy;
    logic [2:0]      o_grant_id;
    logic [15:0]     o_ops_done;

    div_arbiter #(.N_REQ(N), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .i_req_a     (i_req_a),
        .i_req_b     (i_req_b),
        .i_req_stb   (i_req_stb),
        .o_req_ack   (o_req_ack),
        .o_res_z     (o_res_z),
        .o_res_stb   (o_res_stb),
        .i_res_ack   (i_res_ack),
        .o_div_a     (o_div_a),
        .o_div_b     (o_div_b),
        .o_div_stb   (o_div_stb),
        .i_div_ack   (i_div_ack),
        .i_div_z     (i_div_z),
        .i_div_z_stb (i_div_z_stb),
        .o_div_z_ack (o_div_z_ack),
        .o_busy      (o_busy),
        .o_grant_id  (o_grant_id),
        .o_ops_done  (o_ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural divider state
    logic          dv_en = 1'b1;
    logic          dv_force = 1'b0;
    logic [DW-1:0] dv_force_z = '0;
    int            dv_lat_fix = -1;
    int            dv_st = 0;
    int            dv_cnt = 0;
    logic          dv_seen_stb = 1'b0;
    logic [DW-1:0] dv_a = '0, dv_b = '0;

    // requester / scoreboard model state
    logic          rq_auto = 1'b0;
    logic          rq_rand = 1'b0;
    int            mdl_last = N - 1;
    logic [15:0]   mdl_ops = '0;
    int            cur = 0;
    logic [DW-1:0] exp_z = '0;
    logic          ack_hit = 1'b0;
    int            rq_done = 0;
    int            wait_cnt[N];
    int            grant_log[$];
    logic          prev_busy = 1'b0;

    typedef struct {
        int            req;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] z;
        int            hold;
        logic [15:0]   ops;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int k);
        return {{(N-1){1'b0}}, 1'b1} << k;
    endfunction

    function automatic logic [DW-1:0] dv_func(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return {a[15:0], b[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int rr_pick(input int last, input logic [N-1:0] stb);
        for (int i = 1; i <= N; i++) begin
            if (stb[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    task automatic dv_step();
        if (!i_rst_n) begin
            dv_st = 0;
            i_div_ack = 1'b0;
            i_div_z_stb = 1'b0;
            dv_seen_stb = 1'b0;
            return;
        end
        case (dv_st)
            0: begin
                if (i_div_ack && dv_seen_stb) begin
                    dv_a = o_div_a;
                    dv_b = o_div_b;
                    dv_cnt = (dv_lat_fix >= 0) ? dv_lat_fix : int'($urandom_range(0, 3));
                    dv_st = 1;
                    i_div_ack = 1'b0;
                end else begin
                    i_div_ack = o_div_stb && ($urandom_range(0, 2) != 0);
                end
            end
            1: begin
                if (dv_cnt == 0) begin
                    i_div_z = dv_force ? dv_force_z : dv_func(dv_a, dv_b);
                    i_div_z_stb = 1'b1;
                    dv_st = 2;
                end else begin
                    dv_cnt--;
                end
            end
            default: begin
                if (o_div_z_ack) begin
                    i_div_z_stb = 1'b0;
                    dv_st = 0;
                end
            end
        endcase
        dv_seen_stb = o_div_stb;
    endtask

    task automatic rq_step();
        int k;
        logic [DW-1:0] a, b;
        if (ack_hit) begin
            ack_hit = 1'b0;
            mdl_ops = mdl_ops + 16'd1;
            mdl_last = cur;
            rq_done++;
            chk("ops_done", {16'h0, o_ops_done}, {16'h0, mdl_ops});
            chk("res_clr", {28'h0, o_res_stb}, 32'h0);
        end
        if (o_req_ack != '0) begin
            k = 0;
            for (int j = 0; j < N; j++) if (o_req_ack[j]) k = j;
            chk("ack_onehot", $countones(o_req_ack), 1);
            chk("ack_in_idle", {31'h0, prev_busy}, 32'h0);
            chk("rr_grant", k, rr_pick(mdl_last, i_req_stb));
            for (int j = 0; j < N; j++) if (j != k && i_req_stb[j]) wait_cnt[j]++;
            chk("no_starve", {31'h0, wait_cnt[k] <= N - 1}, 32'h1);
            wait_cnt[k] = 0;
            a = i_req_a[k*DW +: DW];
            b = i_req_b[k*DW +: DW];
            chk("div_a", o_div_a, a);
            chk("div_b", o_div_b, b);
            exp_z = dv_func(a, b);
            cur = k;
            grant_log.push_back(k);
            i_req_stb[k] = 1'b0;
        end
        i_res_ack = N'($urandom) & ~oh(cur);
        if (o_res_stb != '0 && $urandom_range(0, 2) == 0) begin
            chk("res_stb", {28'h0, o_res_stb}, {28'h0, oh(cur)});
            chk("res_z", o_res_z, exp_z);
            i_res_ack = i_res_ack | oh(cur);
            ack_hit = 1'b1;
        end
        if (rq_rand) begin
            for (int j = 0; j < N; j++) begin
                if (!i_req_stb[j] && $urandom_range(0, 3) == 0) begin
                    i_req_a[j*DW +: DW] = ($urandom_range(0, 7) == 0) ? 32'h7FC0_0000 : $urandom;
                    i_req_b[j*DW +: DW] = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
                    i_req_stb[j] = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (dv_en) dv_step();
        if (rq_auto) rq_step();
        prev_busy = o_busy;
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_ctl"}, {18'h0, o_req_ack, o_res_stb, o_div_stb, o_div_z_ack, o_busy,
            o_grant_id}, 32'h0);
        chk({name, "_res_z"}, o_res_z, 32'h0);
        chk({name, "_div_a"}, o_div_a, 32'h0);
        chk({name, "_div_b"}, o_div_b, 32'h0);
        chk({name, "_ops"}, {16'h0, o_ops_done}, 32'h0);
    endtask

    task automatic reset_dut();
        rq_auto = 1'b0;
        rq_rand = 1'b0;
        @(negedge clk);
        i_rst_n = 1'b0;
        i_req_stb = '0;
        i_res_ack = '0;
        i_req_a = '0;
        i_req_b = '0;
        repeat (2) tick();
        i_rst_n = 1'b1;
        mdl_last = N - 1;
        mdl_ops = '0;
        ack_hit = 1'b0;
        rq_done = 0;
        cur = 0;
        prev_busy = 1'b0;
        for (int j = 0; j < N; j++) wait_cnt[j] = 0;
        grant_log.delete();
    endtask

    task automatic do_op(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] z, input int hold, input logic [15:0] ops);
        int n;
        dv_force = 1'b1;
        dv_force_z = z;
        i_req_a[k*DW +: DW] = a;
        i_req_b[k*DW +: DW] = b;
        i_req_stb[k] = 1'b1;
        n = 0;
        do begin tick(); n++; end while (o_req_ack == '0 && n < 20);
        chk("op_req_ack", {28'h0, o_req_ack}, {28'h0, oh(k)});
        chk("op_grant_id", {29'h0, o_grant_id}, k);
        chk("op_div_a", o_div_a, a);
        chk("op_div_b", o_div_b, b);
        chk("op_div_stb", {31'h0, o_div_stb}, 32'h1);
        i_req_stb[k] = 1'b0;
        tick();
        chk("op_ack_pulse", {28'h0, o_req_ack}, 32'h0);
        n = 0;
        while (o_res_stb == '0 && n < 30) begin tick(); n++; end
        chk("op_res_stb", {28'h0, o_res_stb}, {28'h0, oh(k)});
        chk("op_res_z", o_res_z, z);
        chk("op_z_ack", {30'h0, o_div_z_ack, o_div_stb}, 32'h2);
        for (int i = 0; i < hold; i++) begin
            i_res_ack = N'($urandom) & ~oh(k);
            tick();
            chk("hold_stb", {28'h0, o_res_stb}, {28'h0, oh(k)});
            chk("hold_z", o_res_z, z);
            chk("hold_state", {15'h0, o_busy, o_ops_done}, {15'h0, 1'b1, ops - 16'd1});
            chk("hold_z_ack", {31'h0, o_div_z_ack}, 32'h0);
        end
        i_res_ack = oh(k);
        tick();
        i_res_ack = '0;
        chk("op_res_clr", {28'h0, o_res_stb}, 32'h0);
        chk("op_ops", {16'h0, o_ops_done}, {16'h0, ops});
        chk("op_idle", {31'h0, o_busy}, 32'h0);
        dv_force = 1'b0;
    endtask

    task automatic run_auto(input int target, input int budget);
        int n;
        n = 0;
        while (rq_done < target && n < budget) begin tick(); n++; end
        chk("auto_done", {31'h0, rq_done >= target}, 32'h1);
    endtask

    initial begin
        int n;
        i_rst_n = 1'b0;
        i_req_a = '0;
        i_req_b = '0;
        i_req_stb = '0;
        i_res_ack = '0;
        i_div_ack = 1'b0;
        i_div_z = '0;
        i_div_z_stb = 1'b0;

        vecs[0] = '{req: 0, a: 32'h40C0_0000, b: 32'h4000_0000, z: 32'h4040_0000, hold: 0,
                    ops: 16'd1};
        vecs[1] = '{req: 2, a: 32'h3F80_0000, b: 32'h0000_0000, z: 32'h7F80_0000, hold: 10,
                    ops: 16'd2};
        vecs[2] = '{req: 1, a: 32'h7FC0_0001, b: 32'h4000_0000, z: 32'h7FC0_0001, hold: 3,
                    ops: 16'd3};
        vecs[3] = '{req: 3, a: 32'hFFFF_FFFF, b: 32'h8000_0000, z: 32'h1234_5678, hold: 1,
                    ops: 16'd4};

        reset_dut();
        chk_reset("reset");

        // divider result strobe and result acks while idle must be ignored
        dv_en = 1'b0;
        i_div_z_stb = 1'b1;
        i_div_z = 32'hDEAD_BEEF;
        i_res_ack = '1;
        repeat (3) tick();
        chk("stray_z", {29'h0, o_div_z_ack, o_busy, |o_res_stb}, 32'h0);
        chk("stray_res_z", o_res_z, 32'h0);
        chk("stray_ops", {16'h0, o_ops_done}, 32'h0);
        i_div_z_stb = 1'b0;
        i_res_ack = '0;
        dv_en = 1'b1;

        for (int i = 0; i < 4; i++) begin
            do_op(vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].z, vecs[i].hold, vecs[i].ops);
        end

        // all four request at once: strict 0,1,2,3 order
        reset_dut();
        rq_auto = 1'b1;
        for (int j = 0; j < N; j++) begin
            i_req_a[j*DW +: DW] = 32'h4100_0000 + j;
            i_req_b[j*DW +: DW] = 32'h3F00_0000 + j;
        end
        i_req_stb = '1;
        run_auto(4, 200);
        chk("all4_count", grant_log.size(), 4);
        for (int i = 0; i < grant_log.size(); i++) chk("all4_order", grant_log[i], i);
        chk("all4_ops", {16'h0, o_ops_done}, 32'd4);
        rq_auto = 1'b0;
        i_res_ack = '0;
        tick();

        // last grant = 1, then req1 and req3 together: req3 first
        do_op(1, 32'h4080_0000, 32'h4000_0000, 32'h4000_0000, 0, 16'd5);
        mdl_last = 1;
        mdl_ops = 16'd5;
        rq_done = 0;
        grant_log.delete();
        rq_auto = 1'b1;
        i_req_stb = 4'b1010;
        run_auto(2, 200);
        chk("rr13_count", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            chk("rr13_first", grant_log[0], 3);
            chk("rr13_second", grant_log[1], 1);
        end

        // reset during WAIT_RES abandons the operation
        reset_dut();
        dv_lat_fix = 10;
        i_req_a[0 +: DW] = 32'h4000_0000;
        i_req_b[0 +: DW] = 32'h3F80_0000;
        i_req_stb[0] = 1'b1;
        n = 0;
        do begin tick(); n++; end while (o_req_ack == '0 && n < 20);
        i_req_stb = '0;
        n = 0;
        while (o_div_stb && n < 20) begin tick(); n++; end
        chk("mid_busy", {31'h0, o_busy}, 32'h1);
        i_rst_n = 1'b0;
        #1;
        chk_reset("rst_async");
        repeat (3) tick();
        i_rst_n = 1'b1;
        dv_lat_fix = -1;
        repeat (15) tick();
        chk("rst_abandon", {27'h0, o_busy, o_res_stb}, 32'h0);
        chk("rst_ops", {16'h0, o_ops_done}, 32'h0);
        do_op(0, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 0, 16'd1);

        // randomized traffic against the model
        reset_dut();
        rq_auto = 1'b1;
        rq_rand = 1'b1;
        run_auto(200, 20000);
        rq_auto = 1'b0;
        rq_rand = 1'b0;

        // counter wrap at full rate: one op every 4 cycles
        reset_dut();
        dv_en = 1'b0;
        i_div_ack = 1'b1;
        i_div_z_stb = 1'b1;
        i_div_z = 32'hCAFE_F00D;
        i_req_stb = 4'b0001;
        i_res_ack = 4'b0001;
        n = 0;
        while (o_ops_done != 16'hFFFF && n < 262200) begin tick(); n++; end
        chk("wrap_ffff", {16'h0, o_ops_done}, 32'h0000_FFFF);
        chk("throughput", n, 4 * 65535);
        n = 0;
        while (o_ops_done == 16'hFFFF && n < 10) begin tick(); n++; end
        chk("wrap_zero", {16'h0, o_ops_done}, 32'h0);
        chk("wrap_res_z", o_res_z, 32'hCAFE_F00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
- REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one divider (2..8).
- REQ-002 SHALL have parameter DATA_WIDTH, default 32, operand/result width (IEEE-754 single, passed opaquely).
- REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
- REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
- REQ-005 SHALL have port i_req_a  input  N_REQ*DATA_WIDTH  dividends; requester k at [k*DATA_WIDTH +: DATA_WIDTH].
- REQ-006 SHALL have port i_req_b  input  N_REQ*DATA_WIDTH  divisors; same packing.
- REQ-007 SHALL have port i_req_stb  input  N_REQ  per-requester operand valid.
- REQ-008 SHALL have port o_req_ack  output  N_REQ  operands accepted, one-hot pulse.
- REQ-009 SHALL have port o_res_z  output  DATA_WIDTH  quotient for current grantee.
- REQ-010 SHALL have port o_res_stb  output  N_REQ  one-hot result valid.
- REQ-011 SHALL have port i_res_ack  input  N_REQ  per-requester result consumed.
- REQ-012 SHALL have ports o_div_a, o_div_b  output  DATA_WIDTH each  operands to divider.
- REQ-013 SHALL have ports o_div_stb  output  1;  i_div_ack  input  1  divider operand handshake.
- REQ-014 SHALL have ports i_div_z  input  DATA_WIDTH;  i_div_z_stb  input  1;  o_div_z_ack  output  1  divider result handshake.
- REQ-015 SHALL have ports o_busy  output  1 (state != IDLE);  o_grant_id  output  3  current/last grantee index;  o_ops_done  output  16  completed-operation count.

Function
- REQ-016 SHALL implement FSM IDLE -> ISSUE -> WAIT_RES -> DELIVER -> IDLE; all outputs registered.
- REQ-017 IDLE: if any i_req_stb high, SHALL select winner round-robin starting at (last_grant+1) mod N_REQ, latch its a/b into o_div_a/o_div_b, pulse o_req_ack[winner] for exactly one cycle, set o_grant_id, go to ISSUE next cycle.
- REQ-018 Requests SHALL be sampled only in IDLE; i_req_stb in other states ignored and no o_req_ack issued.
- REQ-019 ISSUE: o_div_stb SHALL be high; transfer occurs on cycle with o_div_stb && i_div_ack; next cycle o_div_stb low, state WAIT_RES.
- REQ-020 WAIT_RES: on i_div_z_stb high, SHALL capture i_div_z into o_res_z and assert o_div_z_ack for exactly that following cycle; go to DELIVER.
- REQ-021 i_div_z_stb outside WAIT_RES SHALL be ignored (o_div_z_ack stays low).
- REQ-022 DELIVER: o_res_stb[grant] SHALL stay high, o_res_z stable, until i_res_ack[grant] sampled high; then o_res_stb cleared, last_grant <= grant, o_ops_done incremented, state IDLE.
- REQ-023 i_res_ack bits of non-grantees SHALL be ignored.
- REQ-024 Minimum cycle count stb-to-IDLE with zero-wait divider/requester: 4 cycles plus divider latency.
- REQ-025 o_ops_done SHALL wrap 0xFFFF -> 0x0000.
- REQ-026 Operand values (including divisor zero, NaN) SHALL pass through unmodified; no arithmetic in this block.
- REQ-027 Single requester continuously requesting SHALL be re-granted each time; no starvation: any held request granted within N_REQ operations.

Reset
- REQ-028 On i_rst_n low, immediately: state IDLE, o_req_ack=0, o_res_stb=0, o_div_stb=0, o_div_z_ack=0, o_busy=0, o_res_z=0, o_div_a=0, o_div_b=0, o_ops_done=0, o_grant_id=0, last_grant=N_REQ-1 (requester 0 first priority).
- REQ-029 Reset mid-operation SHALL abandon the transaction without delivering a result; divider reset is shared via i_rst_n.

Verification
- REQ-030 Single request: req0 a=0x40C00000 (6.0), b=0x40000000 (2.0) -> one o_req_ack[0] pulse, o_div_stb until i_div_ack, o_res_stb[0] with o_res_z=0x40400000 (3.0), o_ops_done=1.
- REQ-031 All four stb simultaneously after reset -> grants in order 0,1,2,3; o_ops_done=4; each o_req_ack pulsed once.
- REQ-032 Req1 and req3 held, last_grant=1 -> req3 granted before req1.
- REQ-033 Grantee delays i_res_ack 10 cycles, other requester pulses i_res_ack -> o_res_stb/o_res_z held stable 10 cycles, no state change.
- REQ-034 Assert i_rst_n low during WAIT_RES -> all outputs to REQ-028 values same cycle; after release new request to req0 completes normally.
- REQ-035 Preload o_ops_done=0xFFFF via 65535 ops -> next completion reads 0x0000.
